// File: rtl/eco32_core_lsu_dcm_fsm.sv
// Data-cache miss sequencer: optional victim write-back, then an 8-beat line fill into the data RAM.
// Define ECO32_LSU_DCM_TIMEOUT_EN to abort a stalled fill after TIMEOUT_CYCLES silent cycles.
module eco32_core_lsu_dcm_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic        i_tid,
    input  logic        i_wid,
    input  logic        i_dirty,
    input  logic [31:0] i_p_addr,
    input  logic [31:0] i_k_addr,
    output logic        i_ack,
    output logic        m_req_stb,
    output logic        m_req_wr,
    output logic [31:0] m_req_addr,
    input  logic        m_req_rdy,
    output logic        m_wr_stb,
    output logic [31:0] m_wr_data,
    input  logic        m_rd_stb,
    input  logic [31:0] m_rd_data,
    output logic [9:0]  c_rd_addr,
    input  logic [31:0] c_rd_data,
    output logic        c_wr_ena,
    output logic [9:0]  c_wr_addr,
    output logic [31:0] c_wr_data,
    output logic        o_done_stb,
    output logic        o_done_tid,
    output logic        o_done_wid,
    output logic        o_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        WB_DATA   = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_DATA = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        hold;
    logic        accept;
    logic        timeout_fire;
    logic        err_flag;
    logic        tid_q;
    logic        wid_q;
    logic [31:5] p_line;
    logic [31:5] k_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // The FIFO head is stale for one cycle after the pop, so skip it.
            hold  <= (state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tid_q  <= i_tid;
            wid_q  <= i_wid;
            p_line <= i_p_addr[31:5];
            k_line <= i_k_addr[31:5];
        end
    end

`ifdef ECO32_LSU_DCM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state != FILL_DATA || m_rd_stb) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            err_flag <= timeout_fire;
        end
    end

    assign timeout_fire = (state == FILL_DATA) && !m_rd_stb &&
                          (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_fire   = 1'b0;
    assign err_flag       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (i_stb && !hold) begin
                    accept    = 1'b1;
                    state_nxt = i_dirty ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                if (m_req_rdy) begin
                    state_nxt = WB_DATA;
                    cnt_nxt   = '0;
                end
            end
            WB_DATA: begin
                // cnt 0..7 issue RAM reads; cnt 1..8 forward the returned word.
                if (cnt == 4'd8) begin
                    state_nxt = FILL_REQ;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FILL_REQ: begin
                if (m_req_rdy) begin
                    state_nxt = FILL_DATA;
                    cnt_nxt   = '0;
                end
            end
            FILL_DATA: begin
                if (m_rd_stb) begin
                    if (cnt[2:0] == 3'd7) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = {1'b0, cnt[2:0] + 3'd1};
                    end
                end else if (timeout_fire) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        i_ack      = (state == DONE);
        o_done_stb = (state == DONE);
        o_done_tid = tid_q;
        o_done_wid = wid_q;
        o_err      = (state == DONE) && err_flag;
        m_req_stb  = (state == WB_REQ) || (state == FILL_REQ);
        m_req_wr   = (state == WB_REQ);
        m_req_addr = (state == WB_REQ) ? {k_line, 5'b0} : {p_line, 5'b0};
        m_wr_stb   = (state == WB_DATA) && (cnt != 4'd0);
        m_wr_data  = c_rd_data;
        c_rd_addr  = {wid_q, k_line[10:5], cnt[2:0]};
        c_wr_ena   = (state == FILL_DATA) && m_rd_stb;
        c_wr_addr  = {wid_q, p_line[10:5], cnt[2:0]};
        c_wr_data  = m_rd_data;
    end

endmodule
